// File: rtl/turbo_encoder_if.sv
// ---------------------------------------------------------------------------
// turbo_encoder_if
// Handshake and data bundle between a block source and the turbo encoder.
//   start_i  : start request (sampled by the encoder only while idle)
//   data_i   : 5-bit info word, bit 0 encoded first
//   busy_o   : encoder is working on a block
//   valid_o  : one-cycle pulse, the four packed words are fresh
//   sys1_o   : systematic symbols + encoder-1 tail (7 x 4-bit)
//   enc1_o   : encoder-1 parity symbols
//   sys2_o   : interleaved systematic symbols + encoder-2 tail
//   enc2_o   : encoder-2 parity symbols
// master : the block source / consumer side
// slave  : the encoder side
// ---------------------------------------------------------------------------
interface turbo_encoder_if;
    logic        start_i;
    logic [4:0]  data_i;
    logic        busy_o;
    logic        valid_o;
    logic [27:0] sys1_o;
    logic [27:0] enc1_o;
    logic [27:0] sys2_o;
    logic [27:0] enc2_o;

    modport master (
        output start_i, data_i,
        input  busy_o, valid_o, sys1_o, enc1_o, sys2_o, enc2_o
    );

    modport slave (
        input  start_i, data_i,
        output busy_o, valid_o, sys1_o, enc1_o, sys2_o, enc2_o
    );
endinterface

// File: rtl/turbo_encoder.sv
// ---------------------------------------------------------------------------
// turbo_encoder
// Rate-1/3 turbo encoder: two identical 4-state RSC encoders (feedback 1+D^2,
// feedforward 1), the second fed through a fixed 5-entry interleaver. Each
// encoder is driven back to state 0 with two tail bits. Results are BPSK
// soft symbols (bit 1 -> +AMP, bit 0 -> -AMP), packed 7 per 28-bit word with
// symbol j in bits [27-4j : 24-4j].
// Ports:
//   clk_i     : clock, rising edge
//   reset_n_i : asynchronous active-low reset
//   bus       : turbo_encoder_if.slave (start/data in, busy/valid/words out)
// ---------------------------------------------------------------------------
module turbo_encoder #(
    parameter int                 INPUT_SIZE  = 5,
    parameter int                 EXTEND_SIZE = 7,
    parameter logic signed [3:0]  AMP         = 4'sd3,
    parameter logic [14:0]        INTLV       = 15'h3302
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    turbo_encoder_if.slave  bus
);

    localparam int         W         = 4 * EXTEND_SIZE;
    localparam logic [2:0] LAST_INFO = 3'(INPUT_SIZE - 1);
    localparam logic [2:0] LAST_TAIL = 3'(EXTEND_SIZE - 1);
    localparam logic [3:0] SYM_ONE   = AMP;
    localparam logic [3:0] SYM_ZERO  = -AMP;

    typedef enum logic [1:0] {ST_IDLE, ST_ENCODE, ST_TAIL} state_t;

    state_t         r_state;
    logic [2:0]     r_cnt;
    logic [4:0]     r_data;
    logic [1:0]     r_s1;
    logic [1:0]     r_s2;
    logic [W-1:0]   r_sys1, r_enc1, r_sys2, r_enc2;
    logic [W-1:0]   r_sys1_out, r_enc1_out, r_sys2_out, r_enc2_out;
    logic           r_busy;
    logic           r_valid;

    logic [2:0]     w_perm [0:7];
    logic [7:0]     w_data8;
    logic           w_active, w_tail;
    logic           w_u1, w_u2, w_a1, w_a2;
    logic [3:0]     w_sym_u1, w_sym_p1, w_sym_u2, w_sym_p2;
    logic [W-1:0]   w_sys1_next, w_enc1_next, w_sys2_next, w_enc2_next;

    // Interleaver fields; entries past the info length are padding so the
    // counter can index the table without range concerns.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_perm
            if (gi < INPUT_SIZE) begin : g_used
                assign w_perm[gi] = INTLV[3*gi +: 3];
            end else begin : g_pad
                assign w_perm[gi] = 3'd0;
            end
        end
    endgenerate

    assign w_data8  = {3'b000, r_data};
    assign w_active = (r_state != ST_IDLE);
    assign w_tail   = (r_state == ST_TAIL);

    // Tail input equals s0, which cancels the feedback and drains the state.
    assign w_u1 = w_tail ? r_s1[0] : w_data8[r_cnt];
    assign w_u2 = w_tail ? r_s2[0] : w_data8[w_perm[r_cnt]];
    assign w_a1 = w_u1 ^ r_s1[0];
    assign w_a2 = w_u2 ^ r_s2[0];

    assign w_sym_u1 = w_u1 ? SYM_ONE : SYM_ZERO;
    assign w_sym_p1 = w_a1 ? SYM_ONE : SYM_ZERO;
    assign w_sym_u2 = w_u2 ? SYM_ONE : SYM_ZERO;
    assign w_sym_p2 = w_a2 ? SYM_ONE : SYM_ZERO;

    // Next value of the internal words: only the slot of the current step
    // changes. The output transfer uses these so the last tail symbol is
    // included in the published words.
    generate
        for (genvar gi = 0; gi < EXTEND_SIZE; gi++) begin : g_slot
            logic w_hit;
            assign w_hit = w_active && (r_cnt == 3'(gi));
            assign w_sys1_next[W-1-4*gi -: 4] = w_hit ? w_sym_u1 : r_sys1[W-1-4*gi -: 4];
            assign w_enc1_next[W-1-4*gi -: 4] = w_hit ? w_sym_p1 : r_enc1[W-1-4*gi -: 4];
            assign w_sys2_next[W-1-4*gi -: 4] = w_hit ? w_sym_u2 : r_sys2[W-1-4*gi -: 4];
            assign w_enc2_next[W-1-4*gi -: 4] = w_hit ? w_sym_p2 : r_enc2[W-1-4*gi -: 4];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_data     <= 5'd0;
            r_s1       <= 2'b00;
            r_s2       <= 2'b00;
            r_sys1     <= '0;
            r_enc1     <= '0;
            r_sys2     <= '0;
            r_enc2     <= '0;
            r_sys1_out <= '0;
            r_enc1_out <= '0;
            r_sys2_out <= '0;
            r_enc2_out <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_sys1  <= w_sys1_next;
            r_enc1  <= w_enc1_next;
            r_sys2  <= w_sys2_next;
            r_enc2  <= w_enc2_next;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        r_data  <= bus.data_i;
                        r_s1    <= 2'b00;
                        r_s2    <= 2'b00;
                        r_cnt   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    r_s1  <= {w_a1, r_s1[1]};
                    r_s2  <= {w_a2, r_s2[1]};
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == LAST_INFO) begin
                        r_state <= ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    r_s1 <= {w_a1, r_s1[1]};
                    r_s2 <= {w_a2, r_s2[1]};
                    if (r_cnt == LAST_TAIL) begin
                        r_sys1_out <= w_sys1_next;
                        r_enc1_out <= w_enc1_next;
                        r_sys2_out <= w_sys2_next;
                        r_enc2_out <= w_enc2_next;
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_cnt      <= 3'd0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o  = r_busy;
    assign bus.valid_o = r_valid;
    assign bus.sys1_o  = r_sys1_out;
    assign bus.enc1_o  = r_enc1_out;
    assign bus.sys2_o  = r_sys2_out;
    assign bus.enc2_o  = r_enc2_out;

endmodule
